// File: rtl/uart_word_rx_if.sv
//------------------------------------------------------------------------------
// Module      : uart_word_rx_if
// Description : Word valid/ready handshake between the UART word receiver and its consumer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_word_rx_if #(
  parameter int W = 80
);
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready;

  modport master (output word_data, output word_valid, input  word_ready);
  modport slave  (input  word_data, input  word_valid, output word_ready);
endinterface

`default_nettype wire

// File: rtl/uart_word_rx.sv
//------------------------------------------------------------------------------
// Module      : uart_word_rx
// Description : UART frame receiver packing NUM_BYTES bytes into one handshaked word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_word_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int NUM_BYTES    = 10,
  parameter int PARITY       = 0,
  parameter int GAP_BITS     = 0
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             ena,
  input  wire logic                             serial_in,
  uart_word_rx_if.master                        word_if,
  output logic [$clog2(NUM_BYTES+1)-1:0]        byte_cnt,
  output logic                                  frame_err,
  output logic                                  overrun,
  output logic                                  gap_timeout
);

  localparam int c_W     = NUM_BYTES * DATA_BITS;
  localparam int c_CNT_W = $clog2(NUM_BYTES + 1);
  localparam int c_DIV_W = $clog2(CLKS_PER_BIT);
  localparam int c_BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_HALF  = c_DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_FULL  = c_DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_BIT_W-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_err;
  logic [c_W-1:0]       r_acc;
  logic [c_CNT_W-1:0]   r_byte_cnt;
  logic [c_W-1:0]       r_word_data;
  logic                 r_word_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_gap_timeout;
  logic                 w_rx;
  logic                 w_tick;
  logic                 w_gap_fire;
  logic [c_W-1:0]       w_acc_nxt;

  assign w_rx      = r_sync2;
  assign w_tick    = (r_div == '0);
  assign w_acc_nxt = (r_acc << DATA_BITS) | c_W'(r_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!ena) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (!w_rx) w_state_nxt = S_START;
        S_START:  if (w_tick) w_state_nxt = w_rx ? S_IDLE : S_DATA;
        S_DATA:   if (w_tick && r_bit_idx == c_LAST_BIT)
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (w_tick) w_state_nxt = S_STOP;
        S_STOP:   if (w_tick) w_state_nxt = w_rx ? S_IDLE : S_BREAK;
        S_BREAK:  if (w_rx) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_err         <= 1'b0;
      r_acc         <= '0;
      r_byte_cnt    <= '0;
      r_word_data   <= '0;
      r_word_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
      r_gap_timeout <= 1'b0;
    end else begin
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
      r_gap_timeout <= 1'b0;
      if (r_word_valid && word_if.word_ready) r_word_valid <= 1'b0;

      if (!ena) begin
        r_div      <= '0;
        r_bit_idx  <= '0;
        r_err      <= 1'b0;
        r_acc      <= '0;
        r_byte_cnt <= '0;
      end else begin
        if (r_state == S_IDLE) begin
          if (!w_rx) begin
            r_div     <= c_DIV_HALF;
            r_bit_idx <= '0;
            r_err     <= 1'b0;
          end
        end else if (r_state != S_BREAK) begin
          r_div <= w_tick ? c_DIV_FULL : r_div - 1'b1;
        end

        if (w_tick) begin
          case (r_state)
            S_DATA: begin
              r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
            S_PARITY: begin
              if (w_rx != ((^r_shift) ^ (PARITY == 2))) r_err <= 1'b1;
            end
            S_STOP: begin
              if (w_rx && !r_err) begin
                if (r_byte_cnt == c_LAST_BYTE) begin
                  r_acc      <= '0;
                  r_byte_cnt <= '0;
                  // A consumer taking the held word this cycle frees the slot.
                  if (!r_word_valid || word_if.word_ready) begin
                    r_word_data  <= w_acc_nxt;
                    r_word_valid <= 1'b1;
                  end else begin
                    r_overrun <= 1'b1;
                  end
                end else begin
                  r_acc      <= w_acc_nxt;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (w_gap_fire) begin
          r_acc         <= '0;
          r_byte_cnt    <= '0;
          r_gap_timeout <= 1'b1;
        end
      end
    end
  end

  generate
    if (GAP_BITS > 0) begin : g_gap
      localparam int c_GAP_CYC = GAP_BITS * CLKS_PER_BIT;
      localparam int c_GAP_W   = $clog2(c_GAP_CYC);
      localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_CYC - 1);

      logic [c_GAP_W-1:0] r_gap_cnt;
      logic               w_gap_armed;

      // Leaving IDLE (start detect) disarms and therefore clears the counter.
      assign w_gap_armed = ena && (r_state == S_IDLE) && (r_byte_cnt != '0);
      assign w_gap_fire  = w_gap_armed && (r_gap_cnt == c_GAP_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_gap_cnt <= '0;
        else if (!w_gap_armed || w_gap_fire) r_gap_cnt <= '0;
        else                                r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end else begin : g_no_gap
      assign w_gap_fire = 1'b0;
    end
  endgenerate

  assign word_if.word_data  = r_word_data;
  assign word_if.word_valid = r_word_valid;
  assign byte_cnt           = r_byte_cnt;
  assign frame_err          = r_frame_err;
  assign overrun            = r_overrun;
  assign gap_timeout        = r_gap_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_word_rx
// Description : Bench for uart_word_rx with an 8N1 word instance and an even-parity/timeout instance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_word_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena_a, ena_b, sin_a, sin_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  logic fe_a, ov_a, gt_a, fe_b, ov_b, gt_b;

  uart_word_rx_if #(.W(80)) if_a ();
  uart_word_rx_if #(.W(24)) if_b ();

  uart_word_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(10), .PARITY(0), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .serial_in(sin_a), .word_if(if_a),
    .byte_cnt(cnt_a), .frame_err(fe_a), .overrun(ov_a), .gap_timeout(gt_a));

  uart_word_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .NUM_BYTES(3), .PARITY(1), .GAP_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .serial_in(sin_b), .word_if(if_b),
    .byte_cnt(cnt_b), .frame_err(fe_b), .overrun(ov_b), .gap_timeout(gt_b));

  int n_tests = 0;
  int n_fail  = 0;
  int n_fe_a = 0, n_ov_a = 0, n_gt_a = 0, n_vr_a = 0;
  int n_fe_b = 0, n_ov_b = 0, n_gt_b = 0;
  logic pv_a = 1'b0;
  logic [79:0] cap_q[$];

  // Pulse counters and handshake capture, sampled on the inactive edge.
  always @(negedge clk) begin
    if (fe_a) n_fe_a++;
    if (ov_a) n_ov_a++;
    if (gt_a) n_gt_a++;
    if (fe_b) n_fe_b++;
    if (ov_b) n_ov_b++;
    if (gt_b) n_gt_b++;
    if (if_a.word_valid && !pv_a) n_vr_a++;
    pv_a = if_a.word_valid;
    if (if_a.word_valid && if_a.word_ready) cap_q.push_back(if_a.word_data);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) sin_a = b; else sin_b = b;
    cyc(CPB);
  endtask

  task automatic send_head(input int sel, input logic [7:0] d, input bit has_par, input logic par);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (has_par) drive(sel, par);
  endtask

  task automatic send_byte_a(input logic [7:0] d);
    send_head(0, d, 1'b0, 1'b0);
    drive(0, 1'b1);
  endtask

  // Even parity: parity bit makes the total number of ones even.
  task automatic send_byte_b(input logic [7:0] d);
    send_head(1, d, 1'b1, logic'($countones(d) % 2));
    drive(1, 1'b1);
  endtask

  task automatic send_word_a(input logic [79:0] w);
    for (int k = 0; k < 10; k++) send_byte_a(w[79 - 8*k -: 8]);
  endtask

  function automatic logic [79:0] rand_word();
    logic [79:0] w = '0;
    for (int k = 0; k < 10; k++) w = (w << 8) | 80'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena_a = 1'b1; ena_b = 1'b1; sin_a = 1'b1; sin_b = 1'b1;
    if_a.word_ready = 1'b0; if_b.word_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    n_tests++;
    if ({if_a.word_valid, if_a.word_data, cnt_a, fe_a, ov_a, gt_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got valid=%b data=%h cnt=%0d", if_a.word_valid, if_a.word_data, cnt_a);
    end
    n_tests++;
    if ({if_b.word_valid, if_b.word_data, cnt_b, fe_b, ov_b, gt_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: got valid=%b data=%h cnt=%0d", if_b.word_valid, if_b.word_data, cnt_b);
    end
    rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_normal_word();
    logic [7:0]  bytes [10] = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
    logic [79:0] exp = '0;
    int vr0 = n_vr_a;
    for (int k = 0; k < 10; k++) exp = (exp << 8) | 80'(bytes[k]);
    for (int k = 0; k < 9; k++) send_byte_a(bytes[k]);
    send_head(0, bytes[9], 1'b0, 1'b0);
    sin_a = 1'b1;
    cyc(10);
    @(negedge clk);
    n_tests++;
    if (if_a.word_valid !== 1'b0) begin n_fail++; $display("FAIL valid_early: got %b want 0", if_a.word_valid); end
    cyc(1);
    @(negedge clk);
    n_tests++;
    if (if_a.word_valid !== 1'b1) begin n_fail++; $display("FAIL valid_timing: got %b want 1", if_a.word_valid); end
    cyc(5 + 2 * CPB);
    @(negedge clk);
    n_tests++;
    if (if_a.word_data !== exp) begin n_fail++; $display("FAIL normal_data: got %h want %h", if_a.word_data, exp); end
    n_tests++;
    if (cnt_a !== 4'd0) begin n_fail++; $display("FAIL normal_cnt: got %0d want 0", cnt_a); end
    n_tests++;
    if (n_vr_a - vr0 !== 1) begin n_fail++; $display("FAIL normal_valid_once: got %0d rises want 1", n_vr_a - vr0); end
  endtask

  task automatic test_framing();
    int fe0 = n_fe_a;
    send_head(0, 8'h5A, 1'b0, 1'b0);
    sin_a = 1'b0;
    cyc(3 * CPB);
    @(negedge clk);
    n_tests++;
    if (n_fe_a - fe0 !== 1) begin n_fail++; $display("FAIL framing_pulse: got %0d pulses want 1", n_fe_a - fe0); end
    n_tests++;
    if (cnt_a !== 4'd0) begin n_fail++; $display("FAIL framing_cnt: got %0d want 0", cnt_a); end
    sin_a = 1'b1;
    cyc(CPB);
    send_byte_a(8'h11);
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 4'd1 || n_fe_a - fe0 !== 1) begin
      n_fail++; $display("FAIL framing_recover: got cnt=%0d pulses=%0d want 1/1", cnt_a, n_fe_a - fe0);
    end
  endtask

  task automatic test_overrun();
    logic [79:0] w1 = rand_word();
    logic [79:0] w2 = rand_word();
    int ov0;
    if_a.word_ready = 1'b1; cyc(1); if_a.word_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_a.word_valid !== 1'b0) begin n_fail++; $display("FAIL ready_clear: got %b want 0", if_a.word_valid); end
    ena_a = 1'b0; cyc(2); ena_a = 1'b1; cyc(2);
    ov0 = n_ov_a;
    send_word_a(w1);
    send_word_a(w2);
    cyc(2);
    @(negedge clk);
    n_tests++;
    if (if_a.word_data !== w1 || if_a.word_valid !== 1'b1) begin
      n_fail++; $display("FAIL overrun_hold: got %h valid=%b want %h", if_a.word_data, if_a.word_valid, w1);
    end
    n_tests++;
    if (n_ov_a - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d want 1", n_ov_a - ov0); end
    if_a.word_ready = 1'b1; cyc(1); if_a.word_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_a.word_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_release: got %b want 0", if_a.word_valid); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] exp_q[$];
    int ov0 = n_ov_a;
    cap_q.delete();
    if_a.word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(rand_word());
      send_word_a(exp_q[k]);
    end
    cyc(4);
    if_a.word_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cap_q.size() !== 3 || n_ov_a != ov0) begin
      n_fail++; $display("FAIL b2b_count: got %0d words ov=%0d want 3/0", cap_q.size(), n_ov_a - ov0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_enable_abort();
    logic [79:0] w = rand_word();
    int fe0 = n_fe_a;
    send_byte_a(8'($urandom_range(0, 255)));
    send_byte_a(8'($urandom_range(0, 255)));
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    cyc(CPB / 2);
    ena_a = 1'b0;
    cyc(1);
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 4'd0) begin n_fail++; $display("FAIL ena_cnt: got %0d want 0", cnt_a); end
    sin_a = 1'b1; cyc(4); ena_a = 1'b1; cyc(CPB);
    send_word_a(w);
    cyc(2);
    @(negedge clk);
    n_tests++;
    if (if_a.word_data !== w || if_a.word_valid !== 1'b1 || n_fe_a != fe0) begin
      n_fail++; $display("FAIL ena_fresh_word: got %h valid=%b fe=%0d want %h", if_a.word_data, if_a.word_valid, n_fe_a - fe0, w);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'($urandom_range(0, 255));
    drive(0, 1'b0);
    drive(0, 1'b1);
    cyc(CPB / 2);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({if_a.word_valid, if_a.word_data, cnt_a, fe_a, ov_a, gt_a} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got valid=%b data=%h cnt=%0d want 0", if_a.word_valid, if_a.word_data, cnt_a);
    end
    sin_a = 1'b1; cyc(3); rst_n = 1'b1; cyc(CPB);
    send_byte_a(d);
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 4'd1) begin n_fail++; $display("FAIL reset_fresh: got cnt=%0d want 1", cnt_a); end
  endtask

  task automatic test_glitch();
    int fe0 = n_fe_b;
    int gt0 = n_gt_b;
    sin_b = 1'b0; cyc(3); sin_b = 1'b1; cyc(2 * CPB);
    @(negedge clk);
    n_tests++;
    if (cnt_b !== 2'd0 || n_fe_b != fe0 || n_gt_b != gt0) begin
      n_fail++; $display("FAIL glitch: got cnt=%0d fe=%0d gt=%0d want 0/0/0", cnt_b, n_fe_b - fe0, n_gt_b - gt0);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  b1 = 8'($urandom_range(0, 255));
    logic [7:0]  b2 = 8'($urandom_range(0, 255));
    logic [23:0] exp = {8'h03, b1, b2};
    int fe0 = n_fe_b;
    send_head(1, 8'h03, 1'b1, 1'b1);
    drive(1, 1'b1);
    @(negedge clk);
    n_tests++;
    if (n_fe_b - fe0 !== 1 || cnt_b !== 2'd0) begin
      n_fail++; $display("FAIL parity_bad: got fe=%0d cnt=%0d want 1/0", n_fe_b - fe0, cnt_b);
    end
    send_byte_b(8'h03);
    @(negedge clk);
    n_tests++;
    if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL parity_good: got cnt=%0d want 1", cnt_b); end
    send_byte_b(b1);
    send_byte_b(b2);
    @(negedge clk);
    n_tests++;
    if (if_b.word_data !== exp || if_b.word_valid !== 1'b1) begin
      n_fail++; $display("FAIL parity_word: got %h valid=%b want %h", if_b.word_data, if_b.word_valid, exp);
    end
    if_b.word_ready = 1'b1; cyc(1); if_b.word_ready = 1'b0;
  endtask

  task automatic test_gap_timeout();
    int gt0 = n_gt_b;
    send_byte_b(8'($urandom_range(0, 255)));
    send_byte_b(8'($urandom_range(0, 255)));
    cyc(3 * CPB);
    @(negedge clk);
    n_tests++;
    if (n_gt_b != gt0 || cnt_b !== 2'd2) begin
      n_fail++; $display("FAIL gap_early: got gt=%0d cnt=%0d want 0/2", n_gt_b - gt0, cnt_b);
    end
    cyc(2 * CPB);
    @(negedge clk);
    n_tests++;
    if (n_gt_b - gt0 !== 1 || cnt_b !== 2'd0) begin
      n_fail++; $display("FAIL gap_fire: got gt=%0d cnt=%0d want 1/0", n_gt_b - gt0, cnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_normal_word();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_enable_abort();
    test_glitch();
    test_parity();
    test_gap_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
